hbridge_driver: RTL and testbench

- Drives the two-channel H-bridge from the rover's steering command bus: motor_in[3:0] (per-motor direction pins) and motor_en[1:0] (per-motor enable).
- Turns each static command into PWM enables on the bridge, with:
  - a soft-start duty ramp;
  - a mandatory coast (dead) interval before any drive change.
- Sits between the steering/line-follow logic and the bridge pins.

---
 rtl/motor_pkg.sv | 50 +++++
 rtl/motor_channel.sv | 196 +++++++++++++++++++
 rtl/hbridge_driver.sv | 77 +++++++
 tb/tb_hbridge_driver.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared types for the two-channel H-bridge driver.
// Direction codes, channel states and request decode.
package motor_pkg;

  localparam logic [1:0] DIR_COAST = 2'b00;
  localparam logic [1:0] DIR_REV   = 2'b01;
  localparam logic [1:0] DIR_FWD   = 2'b10;
  localparam logic [1:0] DIR_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_RAMP,
    ST_RUN,
    ST_BRAKE,
    ST_DEAD
  } ch_state_e;

  typedef enum logic [1:0] {
    REQ_OFF,
    REQ_DRIVE,
    REQ_BRAKE
  } req_kind_e;

  typedef struct packed {
    req_kind_e  kind;
    logic [1:0] dir;
  } ch_req_t;

  function automatic ch_req_t decode_req(
    input logic       en,
    input logic [1:0] pair
  );
    ch_req_t r;
    logic    drv;
    drv    = (pair == DIR_FWD) || (pair == DIR_REV);
    r.kind = REQ_OFF;
    r.dir  = DIR_COAST;
    unique case (1'b1)
      !en: r.kind = REQ_OFF;
      en && drv: begin
        r.kind = REQ_DRIVE;
        r.dir  = pair;
      end
      en && !drv: r.kind = REQ_BRAKE;
      default: r.kind = REQ_OFF;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One bridge channel: FSM, dead counter, duty ramp, output regs.
// Soft-start ramp is built only with MOTOR_SOFT_START_EN.
module motor_channel
  import motor_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int DEADTIME_CYC = 50000,
  parameter int RAMP_DIV     = 1000,
  parameter int RAMP_STEP    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_en_i,
  input  logic [1:0]          req_pair_i,
  input  logic [PWM_BITS-1:0] duty_max_i,
  input  logic [PWM_BITS-1:0] pwm_nxt_i,
  output logic [1:0]          hb_pair_o,
  output logic                hb_en_o,
  output logic                dead_busy_o
);

  localparam int DW = $clog2(DEADTIME_CYC + 1);

  typedef logic [PWM_BITS-1:0] duty_t;

  ch_state_e     state_q, state_d;
  logic [1:0]    dir_q, dir_d;
  duty_t         duty_q, duty_d;
  logic [DW-1:0] dead_q, dead_d;
  logic [1:0]    pair_q, pair_d;
  logic          en_q, en_d;
  logic          busy_q, busy_d;

  ch_req_t req;
  logic    drv_same;
  logic    brk_same;
  logic    go_dead;
  logic    take_req;

  assign req      = decode_req(req_en_i, req_pair_i);
  assign drv_same = (req.kind == REQ_DRIVE) && (req.dir == dir_q);
  assign brk_same = (req.kind == REQ_BRAKE);

`ifdef MOTOR_SOFT_START_EN
  localparam int VW = $clog2(RAMP_DIV + 1);

  logic [VW-1:0]     div_q, div_d;
  logic [PWM_BITS:0] ramp_sum;
  duty_t             ramp_nxt;
  logic              tick;

  // Wide add so the step never wraps past the ceiling.
  assign tick     = (div_q == VW'(RAMP_DIV - 1));
  assign ramp_sum = {1'b0, duty_q} + (PWM_BITS+1)'(RAMP_STEP);
  assign ramp_nxt = (ramp_sum >= {1'b0, duty_max_i})
                  ? duty_max_i
                  : ramp_sum[PWM_BITS-1:0];
`else
  logic unused_ramp_cfg;
  assign unused_ramp_cfg = (RAMP_DIV != 0) ^ (RAMP_STEP != 0);
`endif

  always_comb begin
    state_d  = state_q;
    dir_d    = dir_q;
    duty_d   = duty_q;
    dead_d   = dead_q;
    go_dead  = 1'b0;
    take_req = 1'b0;
`ifdef MOTOR_SOFT_START_EN
    div_d    = div_q;
`endif
    case (state_q)
      ST_OFF: begin
        duty_d   = '0;
        take_req = 1'b1;
      end
`ifdef MOTOR_SOFT_START_EN
      ST_RAMP: begin
        if (!drv_same) begin
          go_dead = 1'b1;
        end else if (tick) begin
          div_d  = '0;
          duty_d = ramp_nxt;
          if (ramp_nxt == duty_max_i) state_d = ST_RUN;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      ST_RUN: begin
        if (!drv_same) begin
          go_dead = 1'b1;
        end else if (duty_max_i < duty_q) begin
          duty_d = duty_max_i;
        end else if (duty_max_i > duty_q) begin
`ifdef MOTOR_SOFT_START_EN
          state_d = ST_RAMP;
          div_d   = '0;
`else
          duty_d  = duty_max_i;
`endif
        end
      end
      ST_BRAKE: begin
        if (!brk_same) go_dead = 1'b1;
      end
      ST_DEAD: begin
        if (dead_q == '0) take_req = 1'b1;
        else dead_d = dead_q - 1'b1;
      end
      default: state_d = ST_OFF;
    endcase

    if (go_dead) begin
      state_d = ST_DEAD;
      dead_d  = DW'(DEADTIME_CYC - 1);
      duty_d  = '0;
    end

    // Fresh start from OFF or after the coast interval.
    if (take_req) begin
      unique case (req.kind)
        REQ_DRIVE: begin
          dir_d = req.dir;
`ifdef MOTOR_SOFT_START_EN
          state_d = ST_RAMP;
          duty_d  = '0;
          div_d   = '0;
`else
          state_d = ST_RUN;
          duty_d  = duty_max_i;
`endif
        end
        REQ_BRAKE: begin
          state_d = ST_BRAKE;
          duty_d  = '0;
        end
        default: begin
          state_d = ST_OFF;
          duty_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    pair_d = DIR_COAST;
    en_d   = 1'b0;
    busy_d = 1'b0;
    case (state_d)
      ST_RAMP, ST_RUN: begin
        pair_d = dir_d;
        en_d   = (pwm_nxt_i < duty_d);
      end
      ST_BRAKE: begin
        pair_d = DIR_BRAKE;
        en_d   = 1'b1;
      end
      ST_DEAD: busy_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      dir_q   <= DIR_COAST;
      duty_q  <= '0;
      dead_q  <= '0;
      pair_q  <= DIR_COAST;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      dead_q  <= dead_d;
      pair_q  <= pair_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

`ifdef MOTOR_SOFT_START_EN
  always_ff @(posedge clk) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end
`endif

  assign hb_pair_o   = pair_q;
  assign hb_en_o     = en_q;
  assign dead_busy_o = busy_q;

endmodule

// File: rtl/hbridge_driver.sv
// H-bridge driver top: request register, shared PWM counter, two channels.
// Build with MOTOR_SOFT_START_EN for the soft-start duty ramp.
module hbridge_driver
  import motor_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int DEADTIME_CYC = 50000,
  parameter int RAMP_DIV     = 1000,
  parameter int RAMP_STEP    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          motor_in,
  input  logic [1:0]          motor_en,
  input  logic [PWM_BITS-1:0] duty_max,
  output logic [3:0]          hb_in,
  output logic [1:0]          hb_en,
  output logic [1:0]          dead_busy
);

  logic [3:0]          in_q;
  logic [1:0]          en_q;
  logic [PWM_BITS-1:0] dmax_q;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;

  assign pwm_d = pwm_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_q   <= '0;
      en_q   <= '0;
      dmax_q <= '0;
      pwm_q  <= '0;
    end else begin
      in_q   <= motor_in;
      en_q   <= motor_en;
      dmax_q <= duty_max;
      pwm_q  <= pwm_d;
    end
  end

  // Channels compare against the post-edge count so hb_en lines up with it.
  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEADTIME_CYC(DEADTIME_CYC),
    .RAMP_DIV    (RAMP_DIV),
    .RAMP_STEP   (RAMP_STEP)
  ) u_ch_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_en_i   (en_q[1]),
    .req_pair_i (in_q[3:2]),
    .duty_max_i (dmax_q),
    .pwm_nxt_i  (pwm_d),
    .hb_pair_o  (hb_in[3:2]),
    .hb_en_o    (hb_en[1]),
    .dead_busy_o(dead_busy[1])
  );

  motor_channel #(
    .PWM_BITS    (PWM_BITS),
    .DEADTIME_CYC(DEADTIME_CYC),
    .RAMP_DIV    (RAMP_DIV),
    .RAMP_STEP   (RAMP_STEP)
  ) u_ch_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_en_i   (en_q[0]),
    .req_pair_i (in_q[1:0]),
    .duty_max_i (dmax_q),
    .pwm_nxt_i  (pwm_d),
    .hb_pair_o  (hb_in[1:0]),
    .hb_en_o    (hb_en[0]),
    .dead_busy_o(dead_busy[0])
  );

endmodule

// File: tb/tb_hbridge_driver.sv
// Bench for hbridge_driver: directed scenarios plus random traffic,
// checked each cycle against a behavioural model of the channel rules.
module tb_hbridge_driver;

  localparam int PB    = 4;
  localparam int DT    = 8;
  localparam int RDIV  = 2;
  localparam int RSTEP = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    motor_in;
  logic [1:0]    motor_en;
  logic [PB-1:0] duty_max;
  logic [3:0]    hb_in;
  logic [1:0]    hb_en;
  logic [1:0]    dead_busy;

  int n_checks = 0;
  int n_fail   = 0;

  hbridge_driver #(
    .PWM_BITS    (PB),
    .DEADTIME_CYC(DT),
    .RAMP_DIV    (RDIV),
    .RAMP_STEP   (RSTEP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .motor_in (motor_in),
    .motor_en (motor_en),
    .duty_max (duty_max),
    .hb_in    (hb_in),
    .hb_en    (hb_en),
    .dead_busy(dead_busy)
  );

  always #5 clk = ~clk;

  // Model: mode 0 off, 1 driving, 2 braking, 3 coasting dead.
  int         m_st[2], m_dir[2], m_duty[2], m_age[2], m_left[2];
  bit         m_ramp[2];
  logic [3:0] r_in;
  logic [1:0] r_en;
  int         r_dmax;
  int         m_pwm;
  logic [3:0] e_in;
  logic [1:0] e_en, e_busy;

  task automatic m_launch(input int c, input int k, input int d);
    if (k == 1) begin
      m_st[c]  = 1;
      m_dir[c] = d;
`ifdef MOTOR_SOFT_START_EN
      m_ramp[c] = 1;
      m_age[c]  = 0;
      m_duty[c] = 0;
`else
      m_ramp[c] = 0;
      m_duty[c] = r_dmax;
`endif
    end else begin
      m_st[c]   = (k == 2) ? 2 : 0;
      m_duty[c] = 0;
    end
  endtask

  task automatic m_step(input int c);
    logic [1:0] p;
    int k, d;
    p = r_in[2*c +: 2];
    d = int'(p);
    k = !r_en[c] ? 0 : (p == 2'b10 || p == 2'b01) ? 1 : 2;
    case (m_st[c])
      0: m_launch(c, k, d);
      1: begin
        if (k != 1 || d != m_dir[c]) begin
          m_st[c] = 3; m_left[c] = DT; m_duty[c] = 0;
        end else if (m_ramp[c]) begin
          m_age[c]++;
          if (m_age[c] == RDIV) begin
            m_age[c]  = 0;
            m_duty[c] = (m_duty[c] + RSTEP < r_dmax) ? m_duty[c] + RSTEP : r_dmax;
            if (m_duty[c] == r_dmax) m_ramp[c] = 0;
          end
        end else if (r_dmax < m_duty[c]) begin
          m_duty[c] = r_dmax;
        end else if (r_dmax > m_duty[c]) begin
`ifdef MOTOR_SOFT_START_EN
          m_ramp[c] = 1;
          m_age[c]  = 0;
`else
          m_duty[c] = r_dmax;
`endif
        end
      end
      2: if (k != 2) begin
        m_st[c] = 3; m_left[c] = DT; m_duty[c] = 0;
      end
      default: begin
        if (m_left[c] == 1) m_launch(c, k, d);
        else m_left[c]--;
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_st[c] = 0; m_duty[c] = 0; m_ramp[c] = 0; m_left[c] = 0;
      end
      r_in = '0; r_en = '0; r_dmax = 0; m_pwm = 0;
      e_in = '0; e_en = '0; e_busy = '0;
    end else begin
      m_pwm = (m_pwm + 1) % (1 << PB);
      m_step(0);
      m_step(1);
      r_in = motor_in; r_en = motor_en; r_dmax = int'(duty_max);
      for (int c = 0; c < 2; c++) begin
        e_in[2*c +: 2] = 2'b00; e_en[c] = 1'b0; e_busy[c] = 1'b0;
        case (m_st[c])
          1: begin
            e_in[2*c +: 2] = 2'(m_dir[c]);
            e_en[c] = (m_pwm < m_duty[c]);
          end
          2: begin e_in[2*c +: 2] = 2'b11; e_en[c] = 1'b1; end
          3: e_busy[c] = 1'b1;
          default: ;
        endcase
      end
    end
  end

  task automatic settle(input int n);
    motor_en = 2'b00;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; motor_en = 2'b11; motor_in = 4'b1001; duty_max = 4'd4;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_hold got %b_%b_%b want 0000_00_00", hb_in, hb_en, dead_busy);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL reset_rel cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
      if (i == 0 || i == 1) begin
        n_checks++;
        if (hb_in !== ((i == 0) ? 4'b0000 : 4'b1001)) begin
          n_fail++;
          $display("FAIL reset_lat cyc=%0d got hb_in=%b want %b", i, hb_in,
                   (i == 0) ? 4'b0000 : 4'b1001);
        end
      end
    end
    settle(DT + 4);
  endtask

  task automatic test_ramp();
    int hi = 0;
    motor_en = 2'b10; motor_in = 4'b1000; duty_max = 4'd4;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL ramp cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
      if (i >= 24 && hb_en[1]) hi++;
    end
    n_checks++;
    if (hi != 4) begin
      n_fail++;
      $display("FAIL ramp_pwm high=%0d want 4", hi);
    end
  endtask

  task automatic test_reversal();
    int dead = 0;
    motor_in = 4'b0100;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL reversal cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
      if (dead_busy[1]) dead++;
    end
    n_checks++;
    if (dead != DT) begin
      n_fail++;
      $display("FAIL reversal_dead len=%0d want %0d", dead, DT);
    end
  endtask

  task automatic test_dead_churn();
    int dead = 0;
    logic [1:0] opts[3];
    opts[0] = 2'b01; opts[1] = 2'b10; opts[2] = 2'b00;
    for (int i = 0; i < 34; i++) begin
      if (i == 0) motor_in[3:2] = 2'b10;
      else if (i <= 8) motor_in[3:2] = opts[$urandom_range(0, 2)];
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL churn cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
      if (dead_busy[1]) dead++;
    end
    n_checks++;
    if (dead != DT) begin
      n_fail++;
      $display("FAIL churn_dead len=%0d want %0d", dead, DT);
    end
  endtask

  task automatic test_brake_off();
    int dead = 0;
    motor_en = 2'b01; motor_in = 4'b0011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL brake cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
    end
    n_checks++;
    if ({hb_in[1:0], hb_en[0]} !== 3'b111) begin
      n_fail++;
      $display("FAIL brake_pins got %b_%b want 11_1", hb_in[1:0], hb_en[0]);
    end
    motor_en = 2'b00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL brake_off cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
      if (dead_busy[0]) dead++;
    end
    n_checks++;
    if (dead != DT || {hb_in[1:0], hb_en[0]} !== 3'b000) begin
      n_fail++;
      $display("FAIL brake_off_end dead=%0d pins=%b_%b want %0d 00_0",
               dead, hb_in[1:0], hb_en[0], DT);
    end
  endtask

  task automatic test_duty_drop();
    int hi = 0, dead = 0;
    settle(DT + 4);
    motor_en = 2'b10; motor_in = 4'b1000; duty_max = 4'd12;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL drop_pre cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
    end
    duty_max = 4'd3;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL drop cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
      if (i >= 2 && hb_en[1]) hi++;
      if (dead_busy[1]) dead++;
    end
    n_checks++;
    if (hi != 3 || dead != 0) begin
      n_fail++;
      $display("FAIL drop_pwm high=%0d dead=%0d want 3 0", hi, dead);
    end
  endtask

  task automatic test_random();
    motor_en = 2'b00; motor_in = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) motor_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) motor_en = 2'($urandom);
      if ($urandom_range(0, 19) == 0) duty_max = PB'($urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      @(negedge clk);
      n_checks++;
      if ({hb_in, hb_en, dead_busy} !== {e_in, e_en, e_busy}) begin
        n_fail++;
        $display("FAIL random cyc=%0d got %b_%b_%b want %b_%b_%b",
                 i, hb_in, hb_en, dead_busy, e_in, e_en, e_busy);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; motor_in = '0; motor_en = '0; duty_max = '0;
    test_reset();
    test_ramp();
    test_reversal();
    test_dead_churn();
    test_brake_off();
    test_duty_drop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
